pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage program-counter sequencer for the pipelined MIPS core. It owns the PC register and computes the next PC every cycle from sequential flow, stalls and control-transfer redirects resolved in the decode (D) stage, following MIPS delay-slot semantics. It also flags fetch address faults and, optionally, keeps a return-address stack for checking `jr $ra` targets.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset; also the base of the legal fetch window.
- `IMEM_BYTES`, 16384: size of the legal fetch window in bytes.
- `RAS_DEPTH`, 8: return-address stack entries (power of two, ≥2).

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and all state; redirect ignored while high.
- `redirect_valid`  in  1  D stage holds a control-transfer instruction this cycle.
- `npc_op`  in  2  00 sequential, 01 conditional branch, 10 j/jal, 11 jr/jalr.
- `branch_taken`  in  1  branch condition result, used only when `npc_op`=01.
- `d_pc`  in  32  PC of the instruction in D.
- `imm26`  in  26  instruction index field; low 16 bits are the branch offset.
- `ra`  in  32  forwarded register value for jr/jalr.
- `is_call`  in  1  instruction is jal/jalr (links).
- `is_ret`  in  1  instruction is `jr $ra`.
- `pc`  out  32  current fetch PC (registered).
- `pc4`  out  32  `pc`+4, combinational.
- `pc_fault`  out  1  combinational fetch fault on current `pc`.
- `ras_top`  out  32  top RAS entry (0 when empty).
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- `ret_mismatch`  out  1  registered one-cycle pulse: return target disagreed with RAS.

## Operation
- Priority per cycle: `reset` > `stall` > accepted redirect > sequential.
- Accepted redirect = `redirect_valid` & ~`stall`.
- Next PC on accepted redirect:
  - `npc_op`=00: `pc`+4.
  - `npc_op`=01, taken: `d_pc`+4+(sign-extended `imm26[15:0]` << 2); not taken: `pc`+4.
  - `npc_op`=10: {(`d_pc`+4)[31:28], `imm26`, 2'b00}.
  - `npc_op`=11: `ra`, unmodified, so misaligned values reach `pc`.
- No redirect: `pc`+4. All arithmetic is 32-bit modulo 2^32.
- Delay slot: when the redirect is accepted, `pc` already equals `d_pc`+4. That instruction is fetched normally and the target follows.
- `pc_fault` = `pc[1:0]`≠0, or `pc` < `RESET_PC`, or `pc` ≥ `RESET_PC`+`IMEM_BYTES`. It does not alter sequencing.
- RAS, a circular buffer, changes only on accepted redirects:
  - Push `d_pc`+8 when `is_call` and `npc_op`∈{10,11}.
  - Pop when `is_ret` and `npc_op`=11.
  - Push and pop together: top is replaced by `d_pc`+8 and `ras_count` is unchanged.
  - Push when full: the oldest entry is overwritten and `ras_count` stays at `RAS_DEPTH`.
  - Pop when empty: no state change.
- `ret_mismatch` is set the cycle after a pop when the RAS was empty or the popped entry ≠ `ra`. Otherwise it is 0.

## Timing
- Reset values: `pc`=`RESET_PC`, RAS empty, `ras_count`=0, `ras_top`=0, `ret_mismatch`=0.
- `pc` updates one cycle after inputs are sampled; redirect latency is 1 cycle.
- With `stall` held for N cycles, `pc` and the RAS are frozen for N cycles and no redirect is lost or applied. The D stage is frozen too and re-presents the redirect.
- Reset mid-redirect or mid-stall wins: the state above applies on the next edge.

## Configuration
- `PC_SEQ_RAS_EN` defined: RAS, `ras_top`, `ras_count` and `ret_mismatch` behave as above.
- Not defined: no RAS storage. `ras_top`=0, `ras_count`=0 and `ret_mismatch`=0 constantly, and the ports remain. PC sequencing is identical.

## Test plan
- Reset two cycles then release, no redirect: `pc` = 0x3000, 0x3004, 0x3008 on successive cycles; `pc4` = `pc`+4.
- `redirect_valid`=1, `npc_op`=01, taken, `d_pc`=0x3004, `imm26[15:0]`=0xFFFE: next `pc`=0x3000. Same with not taken: `pc`+4.
- `npc_op`=10, `d_pc`=0x3010, `imm26`=0x0000C10: next `pc`=0x00003040.
- `stall`=1 for 3 cycles with a redirect asserted and `pc`=0x3008: `pc` holds 0x3008. After release the redirect applies next cycle.
- `npc_op`=11, `ra`=0x3002: `pc`=0x3002 with `pc_fault`=1. Sequential flow to 0x7000 also gives `pc_fault`=1.
- With `PC_SEQ_RAS_EN`:
  - jal at `d_pc`=0x3000 then jr $ra with `ra`=0x3008: `ret_mismatch` stays 0.
  - `ra`=0x300C: a 1-cycle `ret_mismatch` pulse.
  - 9 pushes at depth 8: `ras_count`=8 and `ras_top`=the ninth value.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program-counter sequencer for the pipelined MIPS core.
//   Owns the PC register. Computes the next fetch PC every cycle from:
//     - sequential flow
//     - stalls
//     - control transfers resolved in the decode (D) stage, which follow
//       MIPS delay-slot semantics
//   Flags fetch address faults combinationally. Can also keep a circular
//   return-address stack (RAS) for checking `jr $ra` targets.
//
// Optional feature macro: PC_SEQ_RAS_EN
//   Defined   -> RAS storage plus ras_top / ras_count / ret_mismatch.
//   Undefined -> those outputs are tied to 0. The ports remain.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   stall          in   hold PC and RAS; redirect ignored while high
//   redirect_valid in   D stage holds a control-transfer instruction
//   npc_op         in   00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   branch_taken   in   branch condition (npc_op = 01 only)
//   d_pc           in   PC of the instruction in D
//   imm26          in   instruction index; low 16 bits = branch offset
//   ra             in   forwarded register value for jr/jalr
//   is_call        in   instruction links (jal/jalr)
//   is_ret         in   instruction is jr $ra
//   pc             out  current fetch PC (registered)
//   pc4            out  pc + 4 (combinational)
//   pc_fault       out  fetch fault on current pc (combinational)
//   ras_top        out  top RAS entry, 0 when empty
//   ras_count      out  number of valid RAS entries
//   ret_mismatch   out  one-cycle pulse: return target disagreed with RAS
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          IMEM_BYTES = 16384,
  parameter int          RAS_DEPTH  = 8,
  localparam int         CW         = $clog2(RAS_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [1:0]    npc_op,
  input  logic          branch_taken,
  input  logic [31:0]   d_pc,
  input  logic [25:0]   imm26,
  input  logic [31:0]   ra,
  input  logic          is_call,
  input  logic          is_ret,
  output logic [31:0]   pc,
  output logic [31:0]   pc4,
  output logic          pc_fault,
  output logic [31:0]   ras_top,
  output logic [CW-1:0] ras_count,
  output logic          ret_mismatch
);

  // The upper bound is computed at 33 bits so that a window ending exactly
  // at 2^32 cannot wrap to zero.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(IMEM_BYTES);

  logic        accept;
  logic [31:0] d_pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign accept = redirect_valid & ~stall;
  assign d_pc4  = d_pc + 32'd4;
  assign br_off = {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign pc4    = pc + 32'd4;

  // In the delay slot, pc already equals d_pc+4, so "not taken" and
  // "sequential" both simply continue from pc.
  always_comb begin
    next_pc = pc4;
    if (accept) begin
      case (npc_op)
        2'b01:   next_pc = branch_taken ? (d_pc4 + br_off) : pc4;
        2'b10:   next_pc = {d_pc4[31:28], imm26, 2'b00};
        2'b11:   next_pc = ra;
        default: next_pc = pc4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (!stall)
      pc <= next_pc;
  end

  assign pc_fault = (pc[1:0] != 2'b00) || (pc < RESET_PC) ||
                    ({1'b0, pc} >= PC_LIMIT);

`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [31:0]   stack [RAS_DEPTH];
  logic [PW-1:0] top_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [31:0]   link;

  assign push  = accept && is_call && npc_op[1];
  assign pop   = accept && is_ret && (npc_op == 2'b11);
  assign empty = (count == '0);
  assign full  = (count == CW'(RAS_DEPTH));
  assign link  = d_pc + 32'd8;

  // top_ptr always names the newest entry. A push advances it circularly.
  // When the stack is full, that advance lands on the oldest entry and
  // overwrites it. A simultaneous push+pop rewrites the top in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_ptr      <= '0;
      count        <= '0;
      ret_mismatch <= 1'b0;
    end else begin
      ret_mismatch <= pop && (empty || (stack[top_ptr] != ra));
      if (push && !pop) begin
        top_ptr <= top_ptr + 1'b1;
        if (!full)
          count <= count + 1'b1;
      end else if (pop && !push && !empty) begin
        top_ptr <= top_ptr - 1'b1;
        count   <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible below count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push && !pop)
        stack[top_ptr + 1'b1] <= link;
      else if (push && pop)
        stack[top_ptr] <= link;
    end
  end

  assign ras_top   = empty ? 32'd0 : stack[top_ptr];
  assign ras_count = count;
`else
  logic unused_ras;

  assign unused_ras   = ^{is_call, is_ret};
  assign ras_top      = 32'd0;
  assign ras_count    = '0;
  assign ret_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed testbench for pc_sequencer. Inputs change on the falling edge
//   and outputs are sampled on the falling edge, half a cycle after the
//   rising edge that updated them. Expected values are hand-computed.
//   RAS checks follow PC_SEQ_RAS_EN: when the macro is undefined, the RAS
//   outputs are expected to stay at zero.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  npc_op;
  logic        branch_taken;
  logic [31:0] d_pc;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic        is_call;
  logic        is_ret;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        pc_fault;
  logic [31:0] ras_top;
  logic [3:0]  ras_count;
  logic        ret_mismatch;

  int compared;
  int mismatched;

  pc_sequencer dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .npc_op(npc_op),
    .branch_taken(branch_taken),
    .d_pc(d_pc),
    .imm26(imm26),
    .ra(ra),
    .is_call(is_call),
    .is_ret(is_ret),
    .pc(pc),
    .pc4(pc4),
    .pc_fault(pc_fault),
    .ras_top(ras_top),
    .ras_count(ras_count),
    .ret_mismatch(ret_mismatch)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sets every D-stage input at once, for a redirect or a quiet cycle.
  task automatic applyStimulus(input logic rv, input logic [1:0] op,
                               input logic taken, input logic [31:0] dpc,
                               input logic [25:0] imm, input logic [31:0] rav,
                               input logic call, input logic ret);
    redirect_valid = rv;
    npc_op         = op;
    branch_taken   = taken;
    d_pc           = dpc;
    imm26          = imm;
    ra             = rav;
    is_call        = call;
    is_ret         = ret;
  endtask

  // Advances one rising edge, then returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compares one observed value against its expected value and counts a
  // miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    stall      = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);

    // Reset held for two cycles.
    step();
    step();
    checkOutput("reset_pc", pc, 32'h3000);
    checkOutput("reset_pc4", pc4, 32'h3004);
    checkOutput("reset_fault", {31'd0, pc_fault}, 32'd0);
    checkOutput("reset_count", {28'd0, ras_count}, 32'd0);
    checkOutput("reset_top", ras_top, 32'd0);
    checkOutput("reset_mismatch", {31'd0, ret_mismatch}, 32'd0);

    // Sequential flow after reset is released.
    reset = 1'b0;
    step();
    checkOutput("seq_pc_1", pc, 32'h3004);
    checkOutput("seq_pc4_1", pc4, 32'h3008);
    step();
    checkOutput("seq_pc_2", pc, 32'h3008);

    // Taken branch with offset -2 words: 0x3004 + 4 - 8 = 0x3000.
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h3004, 26'h000FFFE, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("branch_taken", pc, 32'h3000);

    // The same branch not taken continues from pc.
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h3004, 26'h000FFFE, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("branch_not_taken", pc, 32'h3004);

    // Jump: {(0x3014)[31:28], 0xC10, 00} = 0x3040.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h3010, 26'h0000C10, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("jump_target", pc, 32'h3040);

    // jr to 0x3008 sets up the stall scenario.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3044, 26'h0, 32'h3008, 1'b0, 1'b0);
    step();
    checkOutput("jr_target", pc, 32'h3008);

    // Stall for three cycles with a jump pending. pc must hold.
    stall = 1'b1;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h3004, 26'h0000C10, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("stall_hold_1", pc, 32'h3008);
    step();
    checkOutput("stall_hold_2", pc, 32'h3008);
    step();
    checkOutput("stall_hold_3", pc, 32'h3008);
    stall = 1'b0;
    step();
    checkOutput("stall_release_jump", pc, 32'h3040);

    // Misaligned jr target passes through and faults.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3044, 26'h0, 32'h3002, 1'b0, 1'b0);
    step();
    checkOutput("jr_misaligned_pc", pc, 32'h3002);
    checkOutput("jr_misaligned_fault", {31'd0, pc_fault}, 32'd1);

    // Last legal word, then the first address past the window.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3044, 26'h0, 32'h6FFC, 1'b0, 1'b0);
    step();
    checkOutput("window_last_pc", pc, 32'h6FFC);
    checkOutput("window_last_fault", {31'd0, pc_fault}, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("window_end_pc", pc, 32'h7000);
    checkOutput("window_end_fault", {31'd0, pc_fault}, 32'd1);

    // Below the window, with pc4 wrapping modulo 2^32.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h7000, 26'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    checkOutput("wrap_pc4", pc4, 32'h0);
    checkOutput("wrap_fault", {31'd0, pc_fault}, 32'd1);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h7000, 26'h0, 32'h2FFC, 1'b0, 1'b0);
    step();
    checkOutput("below_window_fault", {31'd0, pc_fault}, 32'd1);

    // Reset during a stall with a redirect pending wins.
    stall = 1'b1;
    reset = 1'b1;
    step();
    checkOutput("reset_mid_stall", pc, 32'h3000);
    stall = 1'b0;
    reset = 1'b0;

`ifdef PC_SEQ_RAS_EN
    // jal at 0x3000 pushes 0x3008. The matching jr $ra gives no pulse.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h3000, 26'h0000C20, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("jal_count", {28'd0, ras_count}, 32'd1);
    checkOutput("jal_top", ras_top, 32'h3008);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3084, 26'h0, 32'h3008, 1'b0, 1'b1);
    step();
    checkOutput("ret_ok_pc", pc, 32'h3008);
    checkOutput("ret_ok_mismatch", {31'd0, ret_mismatch}, 32'd0);
    checkOutput("ret_ok_count", {28'd0, ras_count}, 32'd0);

    // A wrong return target produces a one-cycle pulse.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h3000, 26'h0000C20, 32'h0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3084, 26'h0, 32'h300C, 1'b0, 1'b1);
    step();
    checkOutput("ret_bad_pulse", {31'd0, ret_mismatch}, 32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("ret_bad_pulse_end", {31'd0, ret_mismatch}, 32'd0);

    // Nine pushes at depth 8: count saturates and the ninth is on top.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h3000 + 32'(i * 16), 26'h0000C00,
                    32'h0, 1'b1, 1'b0);
      step();
    end
    checkOutput("full_count", {28'd0, ras_count}, 32'd8);
    checkOutput("full_top", ras_top, 32'h3088);

    // Popping a matching return exposes the eighth push.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3000, 26'h0, 32'h3088, 1'b0, 1'b1);
    step();
    checkOutput("pop_after_full_count", {28'd0, ras_count}, 32'd7);
    checkOutput("pop_after_full_top", ras_top, 32'h3078);
    checkOutput("pop_after_full_mismatch", {31'd0, ret_mismatch}, 32'd0);

    // Popping an empty stack flags a mismatch and changes nothing.
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3000, 26'h0, 32'h3008, 1'b0, 1'b1);
    step();
    checkOutput("empty_pop_mismatch", {31'd0, ret_mismatch}, 32'd1);
    checkOutput("empty_pop_count", {28'd0, ras_count}, 32'd0);
`else
    // Without RAS storage, a call and a return leave the outputs at zero.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h3000, 26'h0000C20, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("noras_jal_pc", pc, 32'h3080);
    checkOutput("noras_count", {28'd0, ras_count}, 32'd0);
    checkOutput("noras_top", ras_top, 32'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3084, 26'h0, 32'h300C, 1'b0, 1'b1);
    step();
    checkOutput("noras_ret_pc", pc, 32'h300C);
    checkOutput("noras_mismatch", {31'd0, ret_mismatch}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
